ds_inst_receiver: RTL and testbench

Receiving end of the fetch-to-decode handshake. It accepts {pc, inst} beats from the fetch stage under the valid/allow_in protocol and buffers them in a small FIFO. Buffering keeps an instruction alive while decode stalls, because instruction SRAM read data is only valid for one cycle. Wrong-path beats are discarded on a branch flush, and held beats are presented to decode with their own valid/ready handshake.

---
 rtl/ds_inst_receiver_pkg.sv | 15 +
 rtl/ds_inst_receiver_if.sv | 29 ++
 rtl/ds_inst_fifo.sv | 58 +++++
 rtl/ds_inst_receiver.sv | 75 +++++++
 tb/tb_ds_inst_receiver.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ds_inst_receiver_pkg.sv
// Shared constants and helpers for the fetch-to-decode receiver.
// Bus widths mirror the pipeline-wide definitions used by the fetch stage.
package ds_inst_receiver_pkg;

    localparam int PC_W        = 32;
    localparam int INST_W      = 32;
    localparam int FS_TO_DS_WD = PC_W + INST_W;
    localparam int BR_TO_FS_WD = 1 + PC_W;

    // Circular pointer increment that also handles non-power-of-two depths.
    function automatic int wrapInc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ds_inst_receiver_if.sv
// Fetch-to-decode handshake bundle plus the decode-side output handshake.
// master = fetch/decode environment, slave = ds_inst_receiver.
interface ds_inst_receiver_if #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    import ds_inst_receiver_pkg::*;

    logic                   fs_to_ds_valid;
    logic [FS_TO_DS_WD-1:0] fs_to_ds_bus;
    logic                   ds_allow_in;
    logic                   br_flush;
    logic                   out_ready;
    logic                   out_valid;
    logic [PC_W-1:0]        out_pc;
    logic [INST_W-1:0]      out_inst;
    logic [CNT_W-1:0]       occupancy;

    modport master (
        output fs_to_ds_valid, fs_to_ds_bus, br_flush, out_ready,
        input  ds_allow_in, out_valid, out_pc, out_inst, occupancy
    );

    modport slave (
        input  fs_to_ds_valid, fs_to_ds_bus, br_flush, out_ready,
        output ds_allow_in, out_valid, out_pc, out_inst, occupancy
    );

endinterface

// File: rtl/ds_inst_fifo.sv
// Small circular buffer holding {pc, inst} beats between fetch and decode.
// Flush and reset both empty it in one cycle; storage itself is not cleared.
module ds_inst_fifo
    import ds_inst_receiver_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = FS_TO_DS_WD,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;

    // Pointer and occupancy bookkeeping; flush discards everything held.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= PTR_W'(wrapInc(int'(r_wrPtr), DEPTH));
            end
            if (i_pop) begin
                r_rdPtr <= PTR_W'(wrapInc(int'(r_rdPtr), DEPTH));
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/ds_inst_receiver.sv
// Decode-stage receiver: accepts fetch beats under valid/allow_in, buffers them
// so SRAM read data survives decode stalls, drops wrong-path beats on flush.
// Optional macro DS_RECV_BYPASS_EN forwards a beat straight to decode when the
// buffer is empty (zero-latency path); default build has one cycle of latency.
module ds_inst_receiver
    import ds_inst_receiver_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    ds_inst_receiver_if.slave bus
);

    logic [CNT_W-1:0]       w_count;
    logic [FS_TO_DS_WD-1:0] w_head;
    logic                   w_empty;
    logic                   w_allowIn;
    logic                   w_bypass;
    logic                   w_push;
    logic                   w_pop;

    // allow_in looks only at held occupancy (plus reset), so out_ready and
    // br_flush never reach it combinationally; a full buffer frees up one
    // cycle after the pop.
    assign w_empty   = (w_count == '0);
    assign w_allowIn = reset || (w_count < CNT_W'(DEPTH));

`ifdef DS_RECV_BYPASS_EN
    assign w_bypass = w_empty && bus.fs_to_ds_valid && !bus.br_flush && !reset;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed beat that decode takes immediately is never written.
    assign w_push = bus.fs_to_ds_valid && w_allowIn && !bus.br_flush && !reset
                    && !(w_bypass && bus.out_ready);
    assign w_pop  = !w_empty && bus.out_ready && !bus.br_flush;

    ds_inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FS_TO_DS_WD),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.br_flush),
        .i_data  (bus.fs_to_ds_bus),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Output mux: bypassed fetch beat, else the buffer head, else zeros.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_pc    = '0;
        bus.out_inst  = '0;
        if (w_bypass) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = bus.fs_to_ds_bus[FS_TO_DS_WD-1:INST_W];
            bus.out_inst  = bus.fs_to_ds_bus[INST_W-1:0];
        end else if (!w_empty) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = w_head[FS_TO_DS_WD-1:INST_W];
            bus.out_inst  = w_head[INST_W-1:0];
        end
    end

    assign bus.ds_allow_in = w_allowIn;
    assign bus.occupancy   = w_count;

endmodule

// File: tb/tb_ds_inst_receiver.sv
// Bench for ds_inst_receiver: DEPTH=2 and DEPTH=3 instances run side by side
// against a queue-based model, plus literal pins on key cycles.
// Honours DS_RECV_BYPASS_EN so the same scenarios cover both builds.
module tb_ds_inst_receiver;

`ifdef DS_RECV_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ds_inst_receiver_if #(.DEPTH(2)) if2 ();
    ds_inst_receiver_if #(.DEPTH(3)) if3 ();

    ds_inst_receiver #(.DEPTH(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
    ds_inst_receiver #(.DEPTH(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

    int nVec = 0;
    int nErr = 0;

    logic [63:0] q2[$];
    logic [63:0] q3[$];
    logic [63:0] fq2[$];
    logic [63:0] fq3[$];
    logic [63:0] dlv2[$];
    logic [63:0] dlv3[$];
    logic [63:0] beats5[10];
    logic [39:0] readyPat;
    bit          flushIn;
    bit          readyIn;
    int          maxOcc2;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected outputs and actions for one lane from the buffer contents.
    task automatic modelLane(input logic [63:0] q[$], input int cap, input bit v,
                             input logic [63:0] beat, input bit fl, input bit rdy,
                             output bit eAllow, output bit eValid, output logic [63:0] eHead,
                             output int eOcc, output bit doPush, output bit doPop,
                             output bit accepted);
        bit byp;
        eOcc     = q.size();
        eAllow   = q.size() < cap;
        byp      = BYP && q.size() == 0 && v && !fl;
        eValid   = q.size() != 0 || byp;
        eHead    = byp ? beat : ((q.size() != 0) ? q[0] : 64'h0);
        doPop    = q.size() != 0 && rdy && !fl;
        accepted = v && eAllow && !fl;
        doPush   = accepted && !(byp && rdy);
    endtask

    task automatic loadBeat(input logic [31:0] pc, input logic [31:0] inst);
        fq2.push_back({pc, inst});
        fq3.push_back({pc, inst});
    endtask

    task automatic applyStimulus(input bit offer, input bit flush, input bit ready);
        if2.fs_to_ds_valid = offer && fq2.size() != 0;
        if2.fs_to_ds_bus   = (fq2.size() != 0) ? fq2[0] : 64'h0;
        if3.fs_to_ds_valid = offer && fq3.size() != 0;
        if3.fs_to_ds_bus   = (fq3.size() != 0) ? fq3[0] : 64'h0;
        if2.br_flush  = flush;
        if3.br_flush  = flush;
        if2.out_ready = ready;
        if3.out_ready = ready;
        flushIn = flush;
        readyIn = ready;
        #1;
    endtask

    // Compare both lanes against the model, then advance model and fetch.
    task automatic checkOutput();
        bit a, v, pu, po, acc;
        logic [63:0] h;
        int o;
        modelLane(q2, 2, if2.fs_to_ds_valid, if2.fs_to_ds_bus, flushIn, readyIn,
                  a, v, h, o, pu, po, acc);
        cmp("d2 allow_in", 64'(if2.ds_allow_in), 64'(a));
        cmp("d2 out_valid", 64'(if2.out_valid), 64'(v));
        cmp("d2 out_pc", 64'(if2.out_pc), 64'(h[63:32]));
        cmp("d2 out_inst", 64'(if2.out_inst), 64'(h[31:0]));
        cmp("d2 occupancy", 64'(if2.occupancy), 64'(o));
        if (if2.out_valid && readyIn && !flushIn) dlv2.push_back({if2.out_pc, if2.out_inst});
        if (int'(if2.occupancy) > maxOcc2) maxOcc2 = int'(if2.occupancy);
        if (flushIn) q2.delete();
        else begin
            if (po) void'(q2.pop_front());
            if (pu) q2.push_back(if2.fs_to_ds_bus);
        end
        if (acc || (flushIn && if2.fs_to_ds_valid)) void'(fq2.pop_front());

        modelLane(q3, 3, if3.fs_to_ds_valid, if3.fs_to_ds_bus, flushIn, readyIn,
                  a, v, h, o, pu, po, acc);
        cmp("d3 allow_in", 64'(if3.ds_allow_in), 64'(a));
        cmp("d3 out_valid", 64'(if3.out_valid), 64'(v));
        cmp("d3 out_pc", 64'(if3.out_pc), 64'(h[63:32]));
        cmp("d3 out_inst", 64'(if3.out_inst), 64'(h[31:0]));
        cmp("d3 occupancy", 64'(if3.occupancy), 64'(o));
        if (if3.out_valid && readyIn && !flushIn) dlv3.push_back({if3.out_pc, if3.out_inst});
        if (flushIn) q3.delete();
        else begin
            if (po) void'(q3.pop_front());
            if (pu) q3.push_back(if3.fs_to_ds_bus);
        end
        if (acc || (flushIn && if3.fs_to_ds_valid)) void'(fq3.pop_front());

        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        if2.fs_to_ds_valid = 1'b0; if3.fs_to_ds_valid = 1'b0;
        if2.br_flush = 1'b0;       if3.br_flush = 1'b0;
        if2.out_ready = 1'b0;      if3.out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            cmp("reset allow d2", 64'(if2.ds_allow_in), 64'd1);
            cmp("reset allow d3", 64'(if3.ds_allow_in), 64'd1);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        q2.delete(); q3.delete(); fq2.delete(); fq3.delete();
        dlv2.delete(); dlv3.delete();
        maxOcc2 = 0;
    endtask

    initial begin
        reset = 1'b1;
        if2.fs_to_ds_bus = 64'h0; if3.fs_to_ds_bus = 64'h0;
        if2.fs_to_ds_valid = 1'b0; if3.fs_to_ds_valid = 1'b0;
        if2.br_flush = 1'b0; if3.br_flush = 1'b0;
        if2.out_ready = 1'b0; if3.out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset then back-to-back stream with decode always ready
        doReset(2);
        loadBeat(32'h1c000000, 32'h00100093);
        loadBeat(32'h1c000004, 32'h00200113);
        loadBeat(32'h1c000008, 32'h00300193);
        applyStimulus(1, 0, 1);
        cmp("t1 c0 pc", 64'(if2.out_pc), BYP ? 64'h1c000000 : 64'h0);
        cmp("t1 c0 allow", 64'(if2.ds_allow_in), 64'd1);
        checkOutput();
        applyStimulus(1, 0, 1);
        cmp("t1 c1 pc", 64'(if2.out_pc), BYP ? 64'h1c000004 : 64'h1c000000);
        cmp("t1 c1 occ", 64'(if2.occupancy), BYP ? 64'd0 : 64'd1);
        cmp("t1 c1 allow", 64'(if2.ds_allow_in), 64'd1);
        checkOutput();
        applyStimulus(1, 0, 1);
        cmp("t1 c2 pc", 64'(if2.out_pc), BYP ? 64'h1c000008 : 64'h1c000004);
        checkOutput();
        applyStimulus(0, 0, 1);
        cmp("t1 c3 pc", 64'(if2.out_pc), BYP ? 64'h0 : 64'h1c000008);
        checkOutput();
        cmp("t1 max occupancy", 64'(maxOcc2), BYP ? 64'd0 : 64'd1);

        // Decode stall fills the buffer, then full push+pop, then drain
        doReset(1);
        loadBeat(32'h1c000040, 32'h11111111);
        loadBeat(32'h1c000044, 32'h22222222);
        loadBeat(32'h1c000048, 32'h33333333);
        applyStimulus(1, 0, 0);
        cmp("t2 k0 occ", 64'(if2.occupancy), 64'd0);
        checkOutput();
        applyStimulus(1, 0, 0);
        cmp("t2 k1 occ", 64'(if2.occupancy), 64'd1);
        checkOutput();
        applyStimulus(1, 0, 0);
        cmp("t2 k2 occ", 64'(if2.occupancy), 64'd2);
        cmp("t2 k2 allow", 64'(if2.ds_allow_in), 64'd0);
        checkOutput();
        applyStimulus(1, 0, 0);
        cmp("t2 k3 held pc", 64'(if2.out_pc), 64'h1c000040);
        checkOutput();
        applyStimulus(1, 0, 1);
        cmp("t3 full pop allow", 64'(if2.ds_allow_in), 64'd0);
        cmp("t3 full pop pc", 64'(if2.out_pc), 64'h1c000040);
        checkOutput();
        applyStimulus(1, 0, 1);
        cmp("t3 after pop occ", 64'(if2.occupancy), 64'd1);
        cmp("t3 after pop allow", 64'(if2.ds_allow_in), 64'd1);
        cmp("t3 after pop pc", 64'(if2.out_pc), 64'h1c000044);
        checkOutput();
        applyStimulus(1, 0, 1);
        cmp("t3 third pc", 64'(if2.out_pc), 64'h1c000048);
        checkOutput();
        applyStimulus(0, 0, 1);
        checkOutput();
        cmp("t2 delivered count", 64'(dlv2.size()), 64'd3);
        cmp("t2 delivered 0", (dlv2.size() > 0) ? dlv2[0] : '1, 64'h1c000040_11111111);
        cmp("t2 delivered 1", (dlv2.size() > 1) ? dlv2[1] : '1, 64'h1c000044_22222222);
        cmp("t2 delivered 2", (dlv2.size() > 2) ? dlv2[2] : '1, 64'h1c000048_33333333);

        // Reset asserted while the buffer is full
        doReset(1);
        loadBeat(32'h1c000080, 32'haaaaaaaa);
        loadBeat(32'h1c000084, 32'hbbbbbbbb);
        applyStimulus(1, 0, 0);
        checkOutput();
        applyStimulus(1, 0, 0);
        checkOutput();
        applyStimulus(0, 0, 0);
        cmp("mid reset pre occ", 64'(if2.occupancy), 64'd2);
        checkOutput();
        doReset(1);
        applyStimulus(0, 0, 0);
        cmp("mid reset occ", 64'(if2.occupancy), 64'd0);
        cmp("mid reset valid", 64'(if2.out_valid), 64'd0);
        cmp("mid reset pc", 64'(if2.out_pc), 64'h0);
        checkOutput();

        // Branch flush discards held and in-flight beats
        doReset(1);
        loadBeat(32'h1c000008, 32'h01010101);
        loadBeat(32'h1c00000c, 32'h02020202);
        loadBeat(32'h1c000010, 32'h03030303);
        applyStimulus(1, 0, 0);
        checkOutput();
        applyStimulus(1, 0, 0);
        checkOutput();
        applyStimulus(1, 1, 0);
        cmp("t4 flush cycle occ", 64'(if2.occupancy), 64'd2);
        checkOutput();
        applyStimulus(0, 0, 1);
        cmp("t4 post flush occ d2", 64'(if2.occupancy), 64'd0);
        cmp("t4 post flush valid d2", 64'(if2.out_valid), 64'd0);
        cmp("t4 post flush occ d3", 64'(if3.occupancy), 64'd0);
        checkOutput();
        loadBeat(32'h1c000100, 32'h04040404);
        applyStimulus(1, 0, 1);
        cmp("t4 target same cycle", 64'(if2.out_pc), BYP ? 64'h1c000100 : 64'h0);
        checkOutput();
        applyStimulus(0, 0, 1);
        cmp("t4 target next cycle", 64'(if2.out_pc), BYP ? 64'h0 : 64'h1c000100);
        checkOutput();
        cmp("t4 delivered count", 64'(dlv2.size()), 64'd1);
        cmp("t4 delivered pc", (dlv2.size() > 0) ? dlv2[0] : '1, 64'h1c000100_04040404);

        // Wrap and zero instruction with an irregular ready pattern
        doReset(1);
        for (int i = 0; i < 10; i++) begin
            beats5[i] = {32'h1c001000 + 32'(4 * i), 32'h00000013 + 32'(i * 32'h100)};
        end
        beats5[3] = {32'h1c00100c, 32'h00000000};
        beats5[7] = {32'h1c00101c, 32'h00000000};
        for (int i = 0; i < 10; i++) loadBeat(beats5[i][63:32], beats5[i][31:0]);
        readyPat = 40'h6D_2B_95_A7_4C;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1, 0, readyPat[k]);
            checkOutput();
        end
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1, 0, 1);
            checkOutput();
        end
        cmp("t5 d3 delivered count", 64'(dlv3.size()), 64'd10);
        cmp("t5 d2 delivered count", 64'(dlv2.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            cmp($sformatf("t5 d3 beat %0d", i), (i < dlv3.size()) ? dlv3[i] : '1, beats5[i]);
            cmp($sformatf("t5 d2 beat %0d", i), (i < dlv2.size()) ? dlv2[i] : '1, beats5[i]);
        end
        cmp("t5 zero inst pin", (dlv3.size() > 3) ? dlv3[3] : '1, 64'h1c00100c_00000000);

        // Empty buffer, decode ready: bypass timing versus registered timing
        doReset(1);
        loadBeat(32'h1c000020, 32'h00500293);
        applyStimulus(1, 0, 1);
        cmp("t6 c0 valid", 64'(if2.out_valid), 64'(BYP));
        cmp("t6 c0 pc", 64'(if2.out_pc), BYP ? 64'h1c000020 : 64'h0);
        cmp("t6 c0 occ", 64'(if2.occupancy), 64'd0);
        checkOutput();
        applyStimulus(0, 0, 1);
        cmp("t6 c1 valid", 64'(if2.out_valid), 64'(!BYP));
        cmp("t6 c1 pc", 64'(if2.out_pc), BYP ? 64'h0 : 64'h1c000020);
        cmp("t6 c1 occ", 64'(if2.occupancy), BYP ? 64'd0 : 64'd1);
        checkOutput();
        applyStimulus(0, 0, 1);
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
